// File: rtl/spi_reg_bank_pkg.sv
// Shared definitions for the SPI register bank: command byte layout and
// controller state encoding.
package spi_reg_bank_pkg;

   localparam int CMD_RW_BIT = 7;
   localparam int ADDR_W     = 7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMD  = 2'd1,
      DATA = 2'd2
   } spi_state_e;

endpackage

// File: rtl/spi_reg_bank_edge_sync.sv
// spi_edge_sync: brings one asynchronous SPI pin into the clk domain and
// produces registered edge pulses.
//   clk, rst   system clock, synchronous active-high reset
//   async_in   raw pin
//   level      synchronized level, aligned with the rise/fall pulses
//   rise/fall  one-cycle pulses, SYNC_STAGES+1 clk after the pin changes
module spi_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
         fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
      end
   end

   // prev_q updates on the same edge as the pulses, so level is the
   // post-edge value whenever rise/fall is high.
   assign level = prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave with an RW register file and RO status
// registers. All SPI pins are oversampled by clk.
//   clk, rst        system clock, synchronous active-high reset
//   spi_cs          chip select, active low
//   spi_clk         SPI clock, idle low
//   spi_mosi        data in, sampled on SCK rise
//   spi_miso        data out, updated after SCK fall
//   rw_data         flat RW registers, reg i = rw_data[8*i+7 -: 8]
//   ro_data         flat RO registers, reg j = ro_data[8*j+7 -: 8]
//   wr_strobe       one-cycle pulse on an RW register write
//   wr_addr         address of the last RW write
//
// state | meaning
// IDLE  | CS high, waiting for CS fall
// CMD   | shifting in the command byte {rw, addr[6:0]}
// DATA  | data bytes; auto-incrementing address
module spi_reg_bank
   import spi_reg_bank_pkg::*;
#(
   parameter int RW_MEMORY_COUNT = 12,
   parameter int RO_MEMORY_COUNT = 1,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         spi_cs,
   input  logic                         spi_clk,
   input  logic                         spi_mosi,
   output logic                         spi_miso,
   output logic [8*RW_MEMORY_COUNT-1:0] rw_data,
   input  logic [8*RO_MEMORY_COUNT-1:0] ro_data,
   output logic                         wr_strobe,
   output logic [ADDR_W-1:0]            wr_addr
);

   localparam int              IDX_W    = $clog2(RW_MEMORY_COUNT);
   localparam logic [ADDR_W:0] RW_LIMIT = (ADDR_W+1)'(RW_MEMORY_COUNT);

   logic cs_level, cs_rise, cs_fall;
   logic sck_level, sck_rise, sck_fall;
   logic mosi_level, mosi_rise, mosi_fall;
   logic unused_sync;

   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .clk(clk), .rst(rst), .async_in(spi_cs),
      .level(cs_level), .rise(cs_rise), .fall(cs_fall)
   );
   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
      .clk(clk), .rst(rst), .async_in(spi_clk),
      .level(sck_level), .rise(sck_rise), .fall(sck_fall)
   );
   spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(clk), .rst(rst), .async_in(spi_mosi),
      .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
   );

   assign unused_sync = ^{cs_level, sck_level, mosi_rise, mosi_fall};

   spi_state_e        state_q, state_d;
   logic [2:0]        bit_cnt_q;
   logic [6:0]        sr_q;
   logic [7:0]        tx_q;
   logic [ADDR_W-1:0] addr_q;
   logic              rw_q;
   logic [7:0]        mem_q [RW_MEMORY_COUNT];

   logic              active, byte_done, wr_en;
   logic [7:0]        rx_byte;

   function automatic logic [7:0] read_reg(input logic [ADDR_W-1:0] a);
      logic [7:0] v;
      v = 8'h00;
      if ({1'b0, a} < RW_LIMIT)
         v = mem_q[a[IDX_W-1:0]];
      for (int j = 0; j < RO_MEMORY_COUNT; j++)
         if ({1'b0, a} == (ADDR_W+1)'(RW_MEMORY_COUNT + j))
            v = ro_data[8*j +: 8];
      return v;
   endfunction

   assign active    = (state_q != IDLE);
   assign byte_done = active && sck_rise && (bit_cnt_q == 3'd7);
   assign rx_byte   = {sr_q, mosi_level};
   assign wr_en     = (state_q == DATA) && byte_done && rw_q && ({1'b0, addr_q} < RW_LIMIT);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (cs_fall) state_d = CMD;
         CMD:     if (byte_done) state_d = DATA;
         DATA:    state_d = DATA;
         default: state_d = IDLE;
      endcase
      // A final-bit commit in the same cycle still happens; only the
      // state and counters are forced back.
      if (cs_rise) state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bit_cnt_q <= 3'd0;
         sr_q      <= '0;
         tx_q      <= '0;
         addr_q    <= '0;
         rw_q      <= 1'b0;
         spi_miso  <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         for (int i = 0; i < RW_MEMORY_COUNT; i++) mem_q[i] <= 8'h00;
      end else begin
         state_q   <= state_d;
         wr_strobe <= wr_en;
         if (wr_en) begin
            mem_q[addr_q[IDX_W-1:0]] <= rx_byte;
            wr_addr                  <= addr_q;
         end

         if (cs_rise) begin
            bit_cnt_q <= 3'd0;
            tx_q      <= '0;
            spi_miso  <= 1'b0;
         end else if (active) begin
            if (sck_rise) begin
               sr_q      <= rx_byte[6:0];
               bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (byte_done && state_q == CMD) begin
               rw_q   <= sr_q[CMD_RW_BIT-1];
               addr_q <= rx_byte[ADDR_W-1:0];
               tx_q   <= sr_q[CMD_RW_BIT-1] ? 8'h00 : read_reg(rx_byte[ADDR_W-1:0]);
            end
            if (byte_done && state_q == DATA)
               addr_q <= addr_q + 1'b1;
            // The fall right after a byte boundary (bit count already wrapped
            // to 0) reloads from the incremented address instead of shifting,
            // so the next MSB is on the line before the next rise.
            if (sck_fall && state_q == DATA && !rw_q)
               tx_q <= (bit_cnt_q == 3'd0) ? read_reg(addr_q) : {tx_q[6:0], 1'b0};
            spi_miso <= tx_q[7];
         end else begin
            spi_miso <= 1'b0;
         end
      end
   end

   for (genvar i = 0; i < RW_MEMORY_COUNT; i++) begin : g_flat
      assign rw_data[8*i +: 8] = mem_q[i];
   end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank. Bit-level SPI master at SCK = clk/8,
// a register model, and queues of expected read bytes and write strobes.
module tb_spi_reg_bank;

   localparam int RW = 12;
   localparam int RO = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          spi_cs = 1'b1;
   logic          spi_clk = 1'b0;
   logic          spi_mosi = 1'b0;
   logic          spi_miso;
   logic [8*RW-1:0] rw_data;
   logic [8*RO-1:0] ro_data = '0;
   logic          wr_strobe;
   logic [6:0]    wr_addr;

   spi_reg_bank #(.RW_MEMORY_COUNT(RW), .RO_MEMORY_COUNT(RO), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .spi_cs(spi_cs), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .rw_data(rw_data), .ro_data(ro_data),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr)
   );

   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_pass = 0;
   logic [7:0] exp_rw [RW];
   logic [7:0] rd_q [$];
   logic [6:0] strb_q [$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [7:0] model_read(input logic [6:0] a);
      if (int'(a) < RW) return exp_rw[a];
      if (int'(a) == RW) return ro_data[7:0];
      return 8'h00;
   endfunction

   task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         spi_clk  = 1'b0;
         spi_mosi = b[i];
         wait_clk(4);
         spi_clk = 1'b1;
         wait_clk(4);
         rx[i] = spi_miso;
      end
   endtask

   task automatic frame_begin();
      spi_cs = 1'b0;
      wait_clk(8);
   endtask

   task automatic frame_end();
      spi_clk = 1'b0;
      wait_clk(4);
      spi_cs = 1'b1;
      wait_clk(8);
   endtask

   task automatic write_frame(input logic [6:0] a, input logic [7:0] d0, input logic [7:0] d1, input int n);
      logic [7:0] rx;
      logic [6:0] p;
      logic [7:0] d;
      p = a;
      frame_begin();
      xfer({1'b1, a}, 8, rx);
      for (int k = 0; k < n; k++) begin
         d = (k == 0) ? d0 : d1;
         if (int'(p) < RW) begin
            strb_q.push_back(p);
            exp_rw[p] = d;
         end
         xfer(d, 8, rx);
         p = p + 7'd1;
      end
      frame_end();
   endtask

   task automatic read_frame(input logic [6:0] a, input int n);
      logic [7:0] rx;
      logic [6:0] p;
      p = a;
      frame_begin();
      xfer({1'b0, a}, 8, rx);
      for (int k = 0; k < n; k++) begin
         rd_q.push_back(model_read(p));
         xfer(8'h00, 8, rx);
         chk($sformatf("read@%0d", p), rx, rd_q.pop_front());
         p = p + 7'd1;
      end
      frame_end();
   endtask

   task automatic check_regs(input string tag);
      for (int i = 0; i < RW; i++)
         chk($sformatf("%s rw[%0d]", tag, i), rw_data[8*i +: 8], exp_rw[i]);
   endtask

   always @(negedge clk) begin
      if (!rst && wr_strobe) begin
         if (strb_q.size() == 0) chk("unexpected wr_strobe, pending", strb_q.size(), 1);
         else chk("wr_addr", wr_addr, strb_q.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] rx;
      for (int i = 0; i < RW; i++) exp_rw[i] = 8'h00;

      wait_clk(5);
      chk("reset miso", spi_miso, 0);
      chk("reset wr_strobe", wr_strobe, 0);
      chk("reset wr_addr", wr_addr, 0);
      check_regs("reset");
      rst = 1'b0;
      wait_clk(10);

      // 1: two-byte write from address 0
      write_frame(7'd0, 8'hA5, 8'h3C, 2);
      check_regs("t1");

      // 2: read back, then abort a read right after the command byte
      read_frame(7'd0, 2);
      check_regs("t2");
      frame_begin();
      xfer(8'h00, 8, rx);
      spi_clk = 1'b0;
      wait_clk(3);
      chk("miso msb after cmd", spi_miso, model_read(7'd0) >> 7);
      spi_cs = 1'b1;
      wait_clk(8);
      chk("miso after cs high", spi_miso, 0);

      // 3: RO status and unmapped reads, plus a read crossing RW->RO->unmapped
      ro_data = 8'h01;
      read_frame(7'd12, 1);
      read_frame(7'd13, 1);
      write_frame(7'd11, 8'h9E, 8'h00, 1);
      read_frame(7'd11, 3);

      // 4: write to RO ignored; address 127 wraps to 0
      write_frame(7'd12, 8'hFF, 8'h00, 1);
      check_regs("t4a");
      write_frame(7'd127, 8'h11, 8'h22, 2);
      check_regs("t4b");

      // 5: partial byte discarded, then a clean write
      frame_begin();
      xfer(8'h82, 8, rx);
      xfer(8'hF0, 4, rx);
      frame_end();
      check_regs("t5a");
      write_frame(7'd2, 8'h77, 8'h00, 1);
      check_regs("t5b");

      // 6: reset mid write frame
      frame_begin();
      xfer(8'h83, 8, rx);
      xfer(8'hAA, 4, rx);
      rst = 1'b1;
      wait_clk(3);
      for (int i = 0; i < RW; i++) exp_rw[i] = 8'h00;
      check_regs("t6 rst");
      chk("t6 miso", spi_miso, 0);
      chk("t6 wr_addr", wr_addr, 0);
      rst = 1'b0;
      spi_clk = 1'b0;
      spi_cs = 1'b1;
      wait_clk(10);
      write_frame(7'd5, 8'h5A, 8'h00, 1);
      check_regs("t6 after");
      read_frame(7'd4, 2);

      wait_clk(10);
      chk("strobes outstanding", strb_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
